// File: rtl/bus_memory_responder_pkg.sv
// Shared bus definitions for the memory responder slice.
// Holds the bus field widths, the beat/wait counter widths, the latched
// command record and the beats = burst_size + 1 helper. FSM encodings are
// deliberately kept inside the top module, not here.
package bus_memory_responder_pkg;

  localparam int DATA_W     = 32;  // bus data / address width
  localparam int BURST_W    = 8;   // burst_sizeIN width (beats minus 1)
  localparam int BE_W       = 4;   // byte enables, one per data byte
  localparam int BEAT_CNT_W = 9;   // must hold 256 (max beats)
  localparam int WAIT_CNT_W = 4;   // must hold WR_WAIT_STATES-1 (0..14)

  // Command fields captured on begin_transactionIN and held for the burst.
  typedef struct packed {
    logic [BE_W-1:0]    be;
    logic [BURST_W-1:0] burst;
  } cmd_t;

  // Number of beats in a transaction: burst_size field + 1 (0 -> 1, 255 -> 256).
  function automatic logic [BEAT_CNT_W-1:0] num_beats(input logic [BURST_W-1:0] burst);
    return BEAT_CNT_W'(burst) + BEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bus_memory_responder_if.sv
// On-chip bus signal bundle between an initiator (master) and the memory
// responder (slave). Signal names keep the bus's IN/OUT suffixes, seen from
// the responder's side.
//   begin_transactionIN  start strobe, qualifies the command fields
//   address_dataIN       command byte address, or write beat data
//   byte_enableIN        per-byte write enable (bit0 = [7:0])
//   burst_sizeIN         beats minus 1
//   read_n_writeIN       1 = read, 0 = write
//   data_validIN         write beat present
//   end_transactionIN    initiator ends a write / aborts a read
//   busyIN               initiator stalls read beats
//   address_dataOUT      read data
//   data_validOUT        read beat valid
//   end_transactionOUT   responder end strobe
//   busyOUT              responder stalls write beats
//   errorOUT             decode error strobe
interface bus_memory_responder_if;
  import bus_memory_responder_pkg::*;

  logic                begin_transactionIN;
  logic [DATA_W-1:0]   address_dataIN;
  logic [BE_W-1:0]     byte_enableIN;
  logic [BURST_W-1:0]  burst_sizeIN;
  logic                read_n_writeIN;
  logic                data_validIN;
  logic                end_transactionIN;
  logic                busyIN;
  logic [DATA_W-1:0]   address_dataOUT;
  logic                data_validOUT;
  logic                end_transactionOUT;
  logic                busyOUT;
  logic                errorOUT;

  modport master (
    output begin_transactionIN, address_dataIN, byte_enableIN, burst_sizeIN,
           read_n_writeIN, data_validIN, end_transactionIN, busyIN,
    input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

  modport slave (
    input  begin_transactionIN, address_dataIN, byte_enableIN, burst_sizeIN,
           read_n_writeIN, data_validIN, end_transactionIN, busyIN,
    output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

endinterface

// File: rtl/bus_memory_responder_ram.sv
// responder_ram: single-port synchronous RAM, DEPTH x 32, byte write enables,
// one cycle read latency. Read-first: a read on a write cycle returns the old
// word. The read register only updates when en=1, so holding en low freezes
// rdata (used by the responder to hold a stalled read beat).
// Ports:
//   clk    clock
//   en     port enable (read and/or write this cycle)
//   we     per-byte write enable, qualified by en
//   addr   word address
//   wdata  write data
//   rdata  registered read data
module responder_ram
  import bus_memory_responder_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // One independent byte-wide array per lane keeps each lane a plain
  // write-enable RAM that maps onto block RAM byte lanes.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        rdata_q <= mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = rdata_q;
  end

endmodule

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: slave end of the on-chip bus. Serves single and burst
// read/write transactions from a local word-addressed RAM at BASE_ADDR.
// Ports:
//   clock  bus clock, rising edge
//   reset  synchronous, active-high; RAM contents survive it
//   bus    slave modport of bus_memory_responder_if
// Parameters:
//   BASE_ADDR      byte address of word 0 (4-byte aligned)
//   SIZE_WORDS     RAM depth in words (power of 2)
//   WR_WAIT_STATES busyOUT cycles after each accepted write beat (0..15)
module bus_memory_responder
  import bus_memory_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          SIZE_WORDS     = 256,
  parameter int          WR_WAIT_STATES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  bus_memory_responder_if.slave  bus
);

  localparam int AW = $clog2(SIZE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_FETCH, S_RD_BEAT, S_WR_BEAT, S_WR_WAIT, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           word_addr_q, word_addr_d;
  cmd_t                    cmd_q, cmd_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic                    ram_en;
  logic [BE_W-1:0]         ram_we;
  logic [DATA_W-1:0]       ram_rdata;

  // Address decode. Testing the offset's upper bits instead of comparing
  // against BASE_ADDR+4*SIZE_WORDS avoids overflow at the top of the map.
  logic [DATA_W-1:0]       offset;
  logic                    addr_hit;
  logic [AW-1:0]           cmd_word;
  logic [BEAT_CNT_W-1:0]   beat_cnt_inc;
  logic                    unused_offset_bits;

  assign offset             = bus.address_dataIN - BASE_ADDR;
  assign addr_hit           = (bus.address_dataIN >= BASE_ADDR) &&
                              (offset[DATA_W-1:AW+2] == '0);
  assign cmd_word           = offset[AW+1:2];
  assign unused_offset_bits = ^offset[1:0];  // byte lane within a word is ignored
  assign beat_cnt_inc       = beat_cnt_q + BEAT_CNT_W'(1);

  responder_ram #(
    .DEPTH (SIZE_WORDS)
  ) u_ram (
    .clk   (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (word_addr_q),
    .wdata (bus.address_dataIN),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      cmd_q       <= '0;
      beat_cnt_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      cmd_q       <= cmd_d;
      beat_cnt_q  <= beat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    cmd_d       = cmd_q;
    beat_cnt_d  = beat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ram_en      = 1'b0;
    ram_we      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.begin_transactionIN) begin
          cmd_d.be    = bus.byte_enableIN;
          cmd_d.burst = bus.burst_sizeIN;
          word_addr_d = cmd_word;
          beat_cnt_d  = '0;
          wait_cnt_d  = '0;
          if (!addr_hit) begin
            state_d = S_ERR;
          end else if (bus.read_n_writeIN) begin
            state_d = S_RD_FETCH;
          end else begin
            state_d = S_WR_BEAT;
          end
        end
      end

      // Issue the first read; word_addr then always points one word ahead
      // of the beat on the bus so a consumed beat is replaced with no bubble.
      S_RD_FETCH: begin
        ram_en      = 1'b1;
        word_addr_d = word_addr_q + AW'(1);
        state_d     = bus.end_transactionIN ? S_IDLE : S_RD_BEAT;
      end

      // While busyIN is high the RAM is not enabled, so its output register
      // (and thus the presented beat) holds.
      S_RD_BEAT: begin
        if (bus.end_transactionIN) begin
          state_d = S_IDLE;
        end else if (!bus.busyIN) begin
          ram_en      = 1'b1;
          word_addr_d = word_addr_q + AW'(1);
          beat_cnt_d  = beat_cnt_inc;
          if (beat_cnt_inc == num_beats(cmd_q.burst)) begin
            state_d = S_DONE;
          end
        end
      end

      // beat_cnt counts written beats; once it reaches the burst length,
      // further beats are accepted but not written.
      S_WR_BEAT: begin
        if (bus.data_validIN) begin
          ram_en = 1'b1;
          if (beat_cnt_q < num_beats(cmd_q.burst)) begin
            ram_we      = cmd_q.be;
            word_addr_d = word_addr_q + AW'(1);
            beat_cnt_d  = beat_cnt_inc;
          end
          if (WR_WAIT_STATES > 0) begin
            state_d    = S_WR_WAIT;
            wait_cnt_d = '0;
          end
        end
        if (bus.end_transactionIN) begin
          state_d = S_IDLE;
        end
      end

      S_WR_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        if (wait_cnt_q == WAIT_CNT_W'(WR_WAIT_STATES - 1)) begin
          state_d = S_WR_BEAT;
        end
        if (bus.end_transactionIN) begin
          state_d = S_IDLE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state, so they are all 0 in IDLE
  // and therefore in the cycle after reset.
  always_comb begin
    bus.data_validOUT      = (state_q == S_RD_BEAT);
    bus.address_dataOUT    = (state_q == S_RD_BEAT) ? ram_rdata : '0;
    bus.end_transactionOUT = (state_q == S_DONE) || (state_q == S_ERR);
    bus.errorOUT           = (state_q == S_ERR);
    bus.busyOUT            = (state_q == S_WR_WAIT);
  end

endmodule
